// File: rtl/pid_core_mc.sv
// ---------------------------------------------------------------------------
// pid_core_mc -- multi-channel incremental (velocity-form) PID controller.
//
// Each channel keeps its own setpoint, P/I/D coefficients and error/output
// history. One sample is processed at a time by a small FSM:
// IDLE -> COMPUTE (COMP_LATENCY cycles) -> SEND (result strobe) -> DONE
// (history write-back) -> IDLE.
//
//   u = u_prev + k1*e + k2*e1 + k3*e2
//   k1 = p+i+d,  k2 = -p-2d,  k3 = d,  e = setpoint - data
//
// All arithmetic is carried at full product width. The sum is then saturated
// to the output range, or to per-channel limits when the optional limit
// feature is built.
//
// Optional feature macro: PID_CORE_MC_LIMIT_EN
//   defined   -> adds max_limit_in / min_limit_in, loaded per channel together
//                with the other parameters
//   undefined -> saturation to the full signed W_OUT range
//
// Ports
//   clk_in, reset_in         clock, synchronous active-high reset
//   data_in, chan_in         signed sample and its channel
//   data_valid_in, ready_out sample handshake (accepted when both are high)
//   setpoint_in, p/i/d_coef_in, param_chan_in, update_en_in, update_in
//                            per-channel parameter load
//   clear_in                 per-channel history clear
//   data_out, chan_out       signed result and its channel
//   data_valid_out, ovf_out  result strobe, saturation flag
// ---------------------------------------------------------------------------
module pid_core_mc #(
    parameter int W_IN         = 18,
    parameter int W_OUT        = 18,
    parameter int W_COEF       = 16,
    parameter int N_CHAN       = 4,
    parameter int W_CHAN       = 2,
    parameter int COMP_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic signed [W_IN-1:0]   data_in,
    input  logic        [W_CHAN-1:0] chan_in,
    input  logic                     data_valid_in,
    output logic                     ready_out,
    input  logic signed [W_COEF-1:0] setpoint_in,
    input  logic signed [W_COEF-1:0] p_coef_in,
    input  logic signed [W_COEF-1:0] i_coef_in,
    input  logic signed [W_COEF-1:0] d_coef_in,
    input  logic        [W_CHAN-1:0] param_chan_in,
    input  logic                     update_en_in,
    input  logic                     update_in,
    input  logic        [N_CHAN-1:0] clear_in,
`ifdef PID_CORE_MC_LIMIT_EN
    input  logic signed [W_OUT-1:0]  max_limit_in,
    input  logic signed [W_OUT-1:0]  min_limit_in,
`endif
    output logic signed [W_OUT-1:0]  data_out,
    output logic        [W_CHAN-1:0] chan_out,
    output logic                     data_valid_out,
    output logic                     ovf_out
);

    localparam int W_E    = W_IN + 1;
    localparam int W_K    = W_COEF + 2;
    localparam int W_PROD = W_K + W_E;
    // Headroom for three products plus u_prev.
    localparam int W_SUM  = ((W_PROD > W_OUT) ? W_PROD : W_OUT) + 2;
    localparam int W_CNT  = (COMP_LATENCY > 1) ? $clog2(COMP_LATENCY) : 1;
    localparam int N_SLOT = 1 << W_CHAN;

    localparam logic signed [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, SEND, DONE} state_t;

    state_t r_state, w_next;

    // Per-channel parameter and history storage.
    logic signed [W_COEF-1:0] r_sp_mem [N_CHAN];
    logic signed [W_COEF-1:0] r_p_mem  [N_CHAN];
    logic signed [W_COEF-1:0] r_i_mem  [N_CHAN];
    logic signed [W_COEF-1:0] r_d_mem  [N_CHAN];
    logic signed [W_E-1:0]    r_e1_mem [N_CHAN];
    logic signed [W_E-1:0]    r_e2_mem [N_CHAN];
    logic signed [W_OUT-1:0]  r_up_mem [N_CHAN];

    // Snapshot of the in-flight sample; later parameter updates cannot touch it.
    logic signed [W_E-1:0]    r_e, r_e1, r_e2;
    logic signed [W_OUT-1:0]  r_up;
    logic signed [W_COEF-1:0] r_p, r_i, r_d;
    logic        [W_CHAN-1:0] r_chan;
    logic        [W_CNT-1:0]  r_cnt;
    logic                     r_clr_hit;
    logic signed [W_OUT-1:0]  r_result;
    logic                     r_ovf;

    logic [N_SLOT-1:0]        w_chan_ok;
    logic                     w_accept, w_upd, w_last;
    logic signed [W_SUM-1:0]  w_k1, w_k2, w_k3, w_sum, w_max, w_min;
    logic signed [W_OUT-1:0]  w_sat;
    logic                     w_ovf;

`ifdef PID_CORE_MC_LIMIT_EN
    logic signed [W_OUT-1:0]  r_max_mem [N_CHAN];
    logic signed [W_OUT-1:0]  r_min_mem [N_CHAN];
    logic signed [W_OUT-1:0]  r_max, r_min;
    assign w_max = W_SUM'(r_max);
    assign w_min = W_SUM'(r_min);
`else
    assign w_max = W_SUM'(OUT_MAX);
    assign w_min = W_SUM'(OUT_MIN);
`endif

    // Channel-legal mask; avoids a compare that is constant for full-range N_CHAN.
    for (genvar g = 0; g < N_SLOT; g++) begin : g_chan_ok
        assign w_chan_ok[g] = (g < N_CHAN);
    end

    assign w_accept = data_valid_in & ready_out & w_chan_ok[chan_in];
    assign w_upd    = update_in & update_en_in & w_chan_ok[param_chan_in];
    assign w_last   = (r_cnt == W_CNT'(COMP_LATENCY - 1));

    // Full-width datapath: every operand is sign-extended to W_SUM first.
    assign w_k1  = W_SUM'(r_p) + W_SUM'(r_i) + W_SUM'(r_d);
    assign w_k2  = -W_SUM'(r_p) - (W_SUM'(r_d) <<< 1);
    assign w_k3  = W_SUM'(r_d);
    assign w_sum = W_SUM'(r_up) + w_k1 * W_SUM'(r_e)
                 + w_k2 * W_SUM'(r_e1) + w_k3 * W_SUM'(r_e2);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_sat = W_OUT'(w_sum);
        w_ovf = 1'b0;
        if (w_min > w_max) begin
            // Inverted limits: the lower limit dominates.
            w_sat = W_OUT'(w_min);
            w_ovf = (w_sum != w_min);
        end else if (w_sum > w_max) begin
            w_sat = W_OUT'(w_max);
            w_ovf = 1'b1;
        end else if (w_sum < w_min) begin
            w_sat = W_OUT'(w_min);
            w_ovf = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset_in) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // FSM next state and handshake output.
    always_comb begin
        w_next    = r_state;
        ready_out = (r_state == IDLE) & ~reset_in;
        case (r_state)
            IDLE:    if (w_accept) w_next = COMPUTE;
            COMPUTE: if (w_last)   w_next = SEND;
            SEND:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            // NOTE: per-channel storage is deliberately reset; history and coefficients must start at zero.
            for (int c = 0; c < N_CHAN; c++) begin
                r_sp_mem[c] <= '0;
                r_p_mem[c]  <= '0;
                r_i_mem[c]  <= '0;
                r_d_mem[c]  <= '0;
                r_e1_mem[c] <= '0;
                r_e2_mem[c] <= '0;
                r_up_mem[c] <= '0;
`ifdef PID_CORE_MC_LIMIT_EN
                r_max_mem[c] <= OUT_MAX;
                r_min_mem[c] <= OUT_MIN;
`endif
            end
            r_e       <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
            r_up      <= '0;
            r_p       <= '0;
            r_i       <= '0;
            r_d       <= '0;
            r_chan    <= '0;
            r_cnt     <= '0;
            r_clr_hit <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
`ifdef PID_CORE_MC_LIMIT_EN
            r_max     <= OUT_MAX;
            r_min     <= OUT_MIN;
`endif
        end else begin
            if (w_accept) begin
                r_e       <= W_E'(r_sp_mem[chan_in]) - W_E'(data_in);
                r_e1      <= r_e1_mem[chan_in];
                r_e2      <= r_e2_mem[chan_in];
                r_up      <= r_up_mem[chan_in];
                r_p       <= r_p_mem[chan_in];
                r_i       <= r_i_mem[chan_in];
                r_d       <= r_d_mem[chan_in];
                r_chan    <= chan_in;
                r_cnt     <= '0;
                r_clr_hit <= clear_in[chan_in];
`ifdef PID_CORE_MC_LIMIT_EN
                r_max     <= r_max_mem[chan_in];
                r_min     <= r_min_mem[chan_in];
`endif
            end else if (r_state != IDLE) begin
                // Remember any clear of the in-flight channel until write-back.
                if (clear_in[r_chan]) r_clr_hit <= 1'b1;
                if (r_state == COMPUTE) r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == COMPUTE && w_last) begin
                r_result <= w_sat;
                r_ovf    <= w_ovf;
            end

            if (w_upd) begin
                r_sp_mem[param_chan_in] <= setpoint_in;
                r_p_mem[param_chan_in]  <= p_coef_in;
                r_i_mem[param_chan_in]  <= i_coef_in;
                r_d_mem[param_chan_in]  <= d_coef_in;
`ifdef PID_CORE_MC_LIMIT_EN
                r_max_mem[param_chan_in] <= max_limit_in;
                r_min_mem[param_chan_in] <= min_limit_in;
`endif
            end

            // Write-back is skipped when the channel was cleared while in flight.
            if (r_state == DONE && !r_clr_hit && !clear_in[r_chan]) begin
                r_up_mem[r_chan] <= r_result;
                r_e2_mem[r_chan] <= r_e1;
                r_e1_mem[r_chan] <= r_e;
            end

            for (int c = 0; c < N_CHAN; c++) begin
                if (clear_in[c]) begin
                    r_e1_mem[c] <= '0;
                    r_e2_mem[c] <= '0;
                    r_up_mem[c] <= '0;
                end
            end
        end
    end

    // Outputs are forced low for the whole time reset is held.
    assign data_valid_out = (r_state == SEND) & ~reset_in;
    assign data_out       = reset_in ? '0 : r_result;
    assign chan_out       = reset_in ? '0 : r_chan;
    assign ovf_out        = data_valid_out & r_ovf;

endmodule

// File: tb/tb_pid_core_mc.sv
// ---------------------------------------------------------------------------
// tb_pid_core_mc -- directed testbench for pid_core_mc.
// The DUT is built with three channels so an out-of-range channel index is
// reachable with a two-bit channel field.
// ---------------------------------------------------------------------------
module tb_pid_core_mc;

    localparam int CL = 2;

    logic               clk_in = 1'b0;
    logic               reset_in;
    logic signed [17:0] data_in;
    logic        [1:0]  chan_in;
    logic               data_valid_in;
    logic               ready_out;
    logic signed [15:0] setpoint_in, p_coef_in, i_coef_in, d_coef_in;
    logic        [1:0]  param_chan_in;
    logic               update_en_in, update_in;
    logic        [2:0]  clear_in;
    logic signed [17:0] data_out;
    logic        [1:0]  chan_out;
    logic               data_valid_out, ovf_out;
`ifdef PID_CORE_MC_LIMIT_EN
    logic signed [17:0] max_limit_in, min_limit_in;
    int lim_max = 131071;
    int lim_min = -131072;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pid_core_mc #(
        .W_IN(18), .W_OUT(18), .W_COEF(16), .N_CHAN(3), .W_CHAN(2), .COMP_LATENCY(CL)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .data_in(data_in), .chan_in(chan_in), .data_valid_in(data_valid_in),
        .ready_out(ready_out),
        .setpoint_in(setpoint_in), .p_coef_in(p_coef_in), .i_coef_in(i_coef_in),
        .d_coef_in(d_coef_in), .param_chan_in(param_chan_in),
        .update_en_in(update_en_in), .update_in(update_in), .clear_in(clear_in),
`ifdef PID_CORE_MC_LIMIT_EN
        .max_limit_in(max_limit_in), .min_limit_in(min_limit_in),
`endif
        .data_out(data_out), .chan_out(chan_out),
        .data_valid_out(data_valid_out), .ovf_out(ovf_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic set_params(input int ch, input int sp, input int p, input int i,
                              input int d, input bit en);
        param_chan_in = 2'(ch);
        setpoint_in   = 16'(sp);
        p_coef_in     = 16'(p);
        i_coef_in     = 16'(i);
        d_coef_in     = 16'(d);
`ifdef PID_CORE_MC_LIMIT_EN
        max_limit_in  = 18'(lim_max);
        min_limit_in  = 18'(lim_min);
`endif
        update_in     = 1'b1;
        update_en_in  = en;
        @(negedge clk_in);
        update_in     = 1'b0;
        update_en_in  = 1'b0;
    endtask

    // mode: 0 plain, 1 extra sample during COMPUTE, 2 clear pulse during
    // COMPUTE, 3 parameter-update pulse (inputs preset by caller) during COMPUTE.
    task automatic send_sample(input int ch, input int d, input int exp_v, input bit exp_ovf,
                               input int mode, input int clr, input string tag);
        logic signed [17:0] e18;
        logic               want_v;
        int w;
        e18 = 18'(exp_v);
        w = 0;
        while (ready_out !== 1'b1 && w < 20) begin
            @(negedge clk_in);
            w++;
        end
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready: got %b want 1", tag, ready_out);
        end
        chan_in = 2'(ch);
        data_in = 18'(d);
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        for (int k = 1; k <= CL + 2; k++) begin
            want_v = (k == CL + 1);
            n_cmp++;
            if (data_valid_out !== want_v) begin
                n_bad++;
                $display("FAIL %s valid@T+%0d: got %b want %b", tag, k, data_valid_out, want_v);
            end
            if (k == CL + 1) begin
                n_cmp++;
                if (data_out !== e18) begin
                    n_bad++;
                    $display("FAIL %s data: got %0d want %0d", tag, data_out, e18);
                end
                n_cmp++;
                if (chan_out !== 2'(ch)) begin
                    n_bad++;
                    $display("FAIL %s chan: got %0d want %0d", tag, chan_out, ch);
                end
                n_cmp++;
                if (ovf_out !== exp_ovf) begin
                    n_bad++;
                    $display("FAIL %s ovf: got %b want %b", tag, ovf_out, exp_ovf);
                end
            end
            if (k == 1) begin
                case (mode)
                    1: begin data_valid_in = 1'b1; chan_in = 2'(ch); data_in = '0; end
                    2: clear_in = 3'(clr);
                    3: begin update_en_in = 1'b1; update_in = 1'b1; end
                    default: ;
                endcase
            end
            @(negedge clk_in);
            data_valid_in = 1'b0;
            clear_in      = '0;
            update_in     = 1'b0;
            update_en_in  = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        n_cmp++;
        if ({ready_out, data_valid_out, ovf_out} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 000", {ready_out, data_valid_out, ovf_out});
        end
        n_cmp++;
        if (data_out !== 18'sd0) begin
            n_bad++;
            $display("FAIL reset_data: got %0d want 0", data_out);
        end
        n_cmp++;
        if (chan_out !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_chan: got %0d want 0", chan_out);
        end
        reset_in = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", ready_out);
        end
    endtask

    task automatic test_proportional();
        do_reset();
        set_params(0, 100, 10, 0, 0, 1'b1);
        send_sample(0, 90, 100, 1'b0, 0, 0, "prop1");
        send_sample(0, 90, 100, 1'b0, 0, 0, "prop2");
    endtask

    task automatic test_integral();
        do_reset();
        set_params(1, 10, 0, 3, 0, 1'b1);
        // Update without enable must be ignored.
        set_params(1, 10, 0, 7, 0, 1'b0);
        send_sample(1, 0, 30, 1'b0, 0, 0, "int1");
        send_sample(1, 0, 60, 1'b0, 0, 0, "int2");
        send_sample(1, 0, 90, 1'b0, 0, 0, "int3");
    endtask

    task automatic test_isolation();
        do_reset();
        set_params(0, 100, 10, 0, 0, 1'b1);
        set_params(1, 10, 0, 3, 0, 1'b1);
        send_sample(0, 90, 100, 1'b0, 0, 0, "iso_c0a");
        send_sample(1, 0, 30, 1'b0, 0, 0, "iso_c1a");
        send_sample(0, 90, 100, 1'b0, 0, 0, "iso_c0b");
        send_sample(1, 0, 60, 1'b0, 1, 0, "iso_c1b_drop");
        send_sample(1, 0, 90, 1'b0, 0, 0, "iso_c1c");
    endtask

    task automatic test_saturation();
        do_reset();
        set_params(2, 1000, 1000, 0, 0, 1'b1);
        send_sample(2, 0, 131071, 1'b1, 0, 0, "sat_pos");
        // e1=1000, u_prev=131071: 131071 - 1e6 - 1e6 clamps low.
        set_params(2, -1000, 1000, 0, 0, 1'b1);
        send_sample(2, 0, -131072, 1'b1, 0, 0, "sat_neg");
`ifdef PID_CORE_MC_LIMIT_EN
        do_reset();
        lim_max = 500;
        set_params(2, 1000, 1000, 0, 0, 1'b1);
        send_sample(2, 0, 500, 1'b1, 0, 0, "lim_max");
        lim_max = -5;
        lim_min = 7;
        set_params(0, 0, 0, 0, 0, 1'b1);
        send_sample(0, 0, 7, 1'b1, 0, 0, "lim_inverted");
        lim_max = 131071;
        lim_min = -131072;
`endif
    endtask

    task automatic test_clear();
        do_reset();
        set_params(1, 10, 0, 3, 0, 1'b1);
        send_sample(1, 0, 30, 1'b0, 0, 0, "clr1");
        send_sample(1, 0, 60, 1'b0, 0, 0, "clr2");
        send_sample(1, 0, 90, 1'b0, 2, 3'b010, "clr3_inflight");
        send_sample(1, 0, 30, 1'b0, 0, 0, "clr4_after");
    endtask

    task automatic test_update_inflight();
        do_reset();
        set_params(1, 10, 0, 3, 0, 1'b1);
        param_chan_in = 2'd1;
        i_coef_in     = 16'sd5;
        send_sample(1, 0, 30, 1'b0, 3, 0, "upd_inflight");
        // New i=5 applies now: 30 + 5*10.
        send_sample(1, 0, 80, 1'b0, 0, 0, "upd_after");
    endtask

    task automatic test_bad_chan();
        do_reset();
        set_params(2, 1000, 1000, 0, 0, 1'b1);
        chan_in = 2'd3;
        data_in = '0;
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            n_cmp++;
            if (data_valid_out !== 1'b0 || ready_out !== 1'b1) begin
                n_bad++;
                $display("FAIL badchan@%0d: got valid=%b ready=%b want 0/1", k, data_valid_out, ready_out);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        set_params(0, 100, 10, 0, 0, 1'b1);
        chan_in = 2'd0;
        data_in = 18'sd90;
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        reset_in = 1'b1;
        @(negedge clk_in);
        n_cmp++;
        if (data_valid_out !== 1'b0 || data_out !== 18'sd0) begin
            n_bad++;
            $display("FAIL midrst_in_reset: got valid=%b data=%0d want 0/0", data_valid_out, data_out);
        end
        reset_in = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: got %b want 1", ready_out);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (data_valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_no_pulse@%0d: got %b want 0", k, data_valid_out);
            end
            @(negedge clk_in);
        end
        // Reset cleared the coefficients, so the result is zero.
        send_sample(0, 90, 0, 1'b0, 0, 0, "midrst_params_cleared");
    endtask

    task automatic test_back_to_back();
        int vals[3];
        int idx;
        logic want_v;
        vals = '{30, 60, 90};
        idx = 0;
        do_reset();
        set_params(1, 10, 0, 3, 0, 1'b1);
        chan_in = 2'd1;
        data_in = '0;
        data_valid_in = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk_in);
            want_v = (j == CL + 1) || (j == CL + 1 + (CL + 3)) || (j == CL + 1 + 2 * (CL + 3));
            n_cmp++;
            if (data_valid_out !== want_v) begin
                n_bad++;
                $display("FAIL b2b_valid@%0d: got %b want %b", j, data_valid_out, want_v);
            end
            if (want_v && idx < 3) begin
                n_cmp++;
                if (data_out !== 18'(vals[idx])) begin
                    n_bad++;
                    $display("FAIL b2b_data%0d: got %0d want %0d", idx, data_out, vals[idx]);
                end
                idx++;
            end
        end
        data_valid_in = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        reset_in      = 1'b1;
        data_in       = '0;
        chan_in       = '0;
        data_valid_in = 1'b0;
        setpoint_in   = '0;
        p_coef_in     = '0;
        i_coef_in     = '0;
        d_coef_in     = '0;
        param_chan_in = '0;
        update_en_in  = 1'b0;
        update_in     = 1'b0;
        clear_in      = '0;
`ifdef PID_CORE_MC_LIMIT_EN
        max_limit_in  = 18'(lim_max);
        min_limit_in  = 18'(lim_min);
`endif
        test_reset();
        test_proportional();
        test_integral();
        test_isolation();
        test_saturation();
        test_clear();
        test_update_inflight();
        test_bad_chan();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pid_core_mc.md
PID_CORE_MC -- requirements
Module: pid_core_mc

Interface
- REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  - W_IN, 18, input data width.
  - W_OUT, 18, output width.
  - W_COEF, 16, coefficient and setpoint width.
  - N_CHAN, 4, channel count.
  - W_CHAN, 2, channel index width.
  - COMP_LATENCY, 2, compute cycles, minimum 1.
- REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk_in, input, 1, system clock.
  - reset_in, input, 1, reset.
  - data_in, input, W_IN, signed sample.
  - chan_in, input, W_CHAN, sample channel.
  - data_valid_in, input, 1, sample strobe.
  - ready_out, output, 1, sample accepted when high.
  - setpoint_in, p_coef_in, i_coef_in, d_coef_in: input, W_COEF each, signed parameters.
  - param_chan_in, input, W_CHAN, target channel for the parameter update.
  - update_en_in, input, 1, update enable.
  - update_in, input, 1, update pulse.
  - clear_in, input, N_CHAN, per-channel history clear.
  - data_out, output, W_OUT, signed result.
  - chan_out, output, W_CHAN, result channel.
  - data_valid_out, output, 1, result strobe.
  - ovf_out, output, 1, saturation flag, qualified by data_valid_out.
- REQ-003 The block SHALL use a single clock, clk_in; reset_in SHALL be synchronous and active-high.

Function
- REQ-004 The block SHALL keep per-channel setpoint, p, i and d, plus history e1, e2 and u_prev; all per-channel state SHALL reset to 0.
- REQ-005 The block SHALL compute e = setpoint - data in W_IN+1 bits and u = u_prev + k1*e + k2*e1 + k3*e2, where k1 = p+i+d, k2 = -p-2d and k3 = d.
- REQ-006 The block SHALL perform all arithmetic at full product width with no truncation before saturation.
- REQ-007 The block SHALL implement a state machine with states IDLE, COMPUTE, SEND and DONE:
  - IDLE -> COMPUTE on an accepted sample.
  - COMPUTE -> SEND after COMP_LATENCY cycles.
  - SEND -> DONE after 1 cycle.
  - DONE -> IDLE after 1 cycle.
- REQ-008 ready_out SHALL be 1 only in IDLE while reset_in is low.
  - A sample is accepted when data_valid_in and ready_out are both 1.
  - A sample presented while ready_out = 0 SHALL be dropped.
- REQ-009 A sample with chan_in >= N_CHAN SHALL be discarded: the block stays in IDLE and produces no output.
- REQ-010 On acceptance in cycle T, the block SHALL latch the sample, channel and that channel's parameters.
  - data_valid_out SHALL be high for exactly cycle T+1+COMP_LATENCY, with data_out and chan_out valid in that cycle.
- REQ-011 In DONE, the block SHALL write u_prev <= data_out, e2 <= e1 and e1 <= e for the latched channel only.
- REQ-012 The block SHALL saturate u to [MIN, MAX] and set ovf_out = 1 whenever clamping occurred; otherwise ovf_out = 0.
- REQ-013 update_in & update_en_in SHALL load the four parameters into channel param_chan_in on the next edge.
  - Parameter updates SHALL NOT affect an in-flight computation.
  - An update to a channel >= N_CHAN SHALL be ignored.
- REQ-014 clear_in[c] = 1 SHALL zero e1, e2 and u_prev of channel c.
  - If c is in flight, the DONE write for c SHALL be suppressed (clear wins).
  - The in-flight output SHALL still be emitted.
- REQ-015 Sustained throughput SHALL be one sample per COMP_LATENCY+3 cycles.

Reset
- REQ-016 While reset_in is high, the block SHALL:
  - force state IDLE;
  - drive data_out, chan_out, data_valid_out, ovf_out and ready_out to 0;
  - clear all per-channel history and parameters.
- REQ-017 Reset mid-operation SHALL abort the computation with no output pulse and no history write; ready_out SHALL be 1 in the first cycle after reset is released.

Configuration
- REQ-018 When PID_CORE_MC_LIMIT_EN is defined, the block SHALL add per-channel signed W_OUT inputs max_limit_in and min_limit_in, loaded with the other parameters in REQ-013.
  - Reset values SHALL be MAX = 2^(W_OUT-1)-1 and MIN = -2^(W_OUT-1).
  - Saturation SHALL clamp to [min_limit, max_limit].
  - If min_limit > max_limit, the output SHALL be min_limit.
- REQ-019 When PID_CORE_MC_LIMIT_EN is undefined, those ports SHALL NOT exist and saturation SHALL be to the full W_OUT range.

Verification (defaults, COMP_LATENCY=2)
- REQ-020 Proportional hold: ch0 p=10, i=0, d=0, sp=100; accept data=90 at T -> data_out=100, chan_out=0, valid at T+3; a second identical sample -> 100.
- REQ-021 Integral ramp: ch1 p=0, i=3, sp=10; three samples with data=0 -> outputs 30, 60, 90; ovf_out=0.
- REQ-022 Channel isolation: ch0 and ch1 configured as in REQ-020 and REQ-021, samples interleaved -> identical values to the separate runs; a sample presented during COMPUTE is dropped with no extra valid pulse.
- REQ-023 Saturation: ch2 p=1000, sp=1000, data=0 -> 131071 with ovf_out=1; with LIMIT_EN and max_limit=500 -> 500 with ovf_out=1.
- REQ-024 Clear/reset: assert clear_in=4'b0010 during ch1 COMPUTE -> output 90 emitted, next ch1 sample yields 30; reset_in during COMPUTE -> no valid pulse and ready_out=1 one cycle after release.
